uart_spi_bridge: RTL and testbench

Parametrised successor to the current UART/SPI top. It bridges a UART link and an SPI slave port through two synchronous FIFOs: bytes received on UART are buffered and shifted out on MISO, and words written on MOSI are buffered and transmitted on UART. Word width, FIFO depth and four baud divisors are parameters, with `freq_control` selecting the divisor at run time. It sits directly under the tile wrapper and replaces `uart_spi_top` in the next tapeout.

---
 rtl/uart_spi_bridge_if.sv | 37 +++
 rtl/uart_spi_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_uart_spi_bridge.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_spi_bridge_if.sv
// uart_spi_bridge_if
//   Pin and status bundle of uart_spi_bridge.
//   slave  : bridge side
//            inputs  freq_control, uart_rx_d_in, cs_bar, sclk, mosi, clear_flags
//            outputs uart_tx_d_out, miso, rx_count, tx_count,
//                    rx_overflow, tx_overflow, frame_err
//   master : environment side, with the opposite directions.
//   CNT_W must equal $clog2(FIFO_DEPTH)+1 of the bridge it connects to.
interface uart_spi_bridge_if #(
  parameter int CNT_W = 3
);
  logic [1:0]       freq_control;
  logic             uart_rx_d_in;
  logic             uart_tx_d_out;
  logic             cs_bar;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             clear_flags;
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W-1:0] tx_count;
  logic             rx_overflow;
  logic             tx_overflow;
  logic             frame_err;

  modport slave (
    input  freq_control, uart_rx_d_in, cs_bar, sclk, mosi, clear_flags,
    output uart_tx_d_out, miso, rx_count, tx_count,
           rx_overflow, tx_overflow, frame_err
  );

  modport master (
    output freq_control, uart_rx_d_in, cs_bar, sclk, mosi, clear_flags,
    input  uart_tx_d_out, miso, rx_count, tx_count,
           rx_overflow, tx_overflow, frame_err
  );
endinterface

// File: rtl/uart_spi_bridge.sv
// uart_spi_bridge
//   UART <-> SPI-slave bridge. Received UART frames are queued in the RX FIFO
//   and shifted out on MISO; words written on MOSI are queued in the TX FIFO
//   and sent as UART frames. freq_control picks one of four baud divisors,
//   latched at the start of every UART frame.
//   Ports: clk, reset (sync, active-high); bus (uart_spi_bridge_if.slave)
//   carrying the UART/SPI pins, clear_flags, FIFO counts and sticky flags.
//   uart_spi_bridge_fifo is the synchronous FIFO used for both directions:
//   push/pop requests, head data, occupancy and a drop pulse when a push is
//   refused because the FIFO is full.

module uart_spi_bridge_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop frees the slot in the same cycle, so push+pop on a full FIFO works.
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != FULL) || do_pop);
  assign overflow = push && !do_push;
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module uart_spi_bridge #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_0      = 868,
  parameter int DIV_1      = 434,
  parameter int DIV_2      = 217,
  parameter int DIV_3      = 108
) (
  input logic               clk,
  input logic               reset,
  uart_spi_bridge_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = 16;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  function automatic logic [DIV_W-1:0] div_sel(input logic [1:0] f);
    logic [DIV_W-1:0] d;
    case (f)
      2'd0:    d = DIV_W'(DIV_0);
      2'd1:    d = DIV_W'(DIV_1);
      2'd2:    d = DIV_W'(DIV_2);
      default: d = DIV_W'(DIV_3);
    endcase
    return d;
  endfunction

  // ---- input synchronisers and edge detection ----
  logic [1:0] rx_sync, cs_sync, sclk_sync, mosi_sync;
  logic       rx_prev, cs_prev, sclk_prev;
  logic       rx_s, cs_s, sclk_s, mosi_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync   <= 2'b11;
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      rx_prev   <= 1'b1;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], bus.uart_rx_d_in};
      cs_sync   <= {cs_sync[0], bus.cs_bar};
      sclk_sync <= {sclk_sync[0], bus.sclk};
      rx_prev   <= rx_s;
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk) mosi_sync <= {mosi_sync[0], bus.mosi};

  assign rx_s   = rx_sync[1];
  assign cs_s   = cs_sync[1];
  assign sclk_s = sclk_sync[1];
  assign mosi_s = mosi_sync[1];

  // A falling edge needs the line to have been high, which also enforces
  // "line seen high again" after a framing error.
  logic rx_fall, cs_fall, sclk_rise, sclk_fall;
  assign rx_fall   = rx_prev & ~rx_s;
  assign cs_fall   = cs_prev & ~cs_s;
  assign sclk_rise = ~sclk_prev & sclk_s & ~cs_s;
  assign sclk_fall = sclk_prev & ~sclk_s & ~cs_s;

  // ---- FIFOs ----
  logic              rx_push, rx_pop, rx_ovf_evt;
  logic              tx_push, tx_pop, tx_ovf_evt;
  logic [DATA_W-1:0] rx_head, tx_head, rx_word, tx_word;
  logic [CNT_W-1:0]  rx_cnt_q, tx_cnt_q;

  uart_spi_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_word), .pop(rx_pop),
    .rdata(rx_head), .count(rx_cnt_q), .overflow(rx_ovf_evt)
  );

  uart_spi_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(tx_word), .pop(tx_pop),
    .rdata(tx_head), .count(tx_cnt_q), .overflow(tx_ovf_evt)
  );

  // ---- UART receiver ----
  uart_state_t       rx_state, rx_next;
  logic [DIV_W-1:0]  rx_div, rx_cnt, rx_limit;
  logic [BIT_W-1:0]  rx_bit;
  logic              rx_tick, rx_ferr;

  // START waits half a bit so every later sample lands mid-bit.
  assign rx_limit = (rx_state == S_START) ? ((rx_div >> 1) - 1'b1) : (rx_div - 1'b1);
  assign rx_tick  = (rx_cnt == rx_limit);

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_tick) rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == LAST_BIT) rx_next = S_STOP;
      S_STOP: begin
        if (rx_tick) begin
          rx_next = S_IDLE;
          rx_push = rx_s;
          rx_ferr = ~rx_s;
        end
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == S_IDLE) begin
        rx_cnt <= '0;
        rx_bit <= '0;
      end else if (rx_tick) begin
        rx_cnt <= '0;
        if (rx_state == S_DATA) rx_bit <= rx_bit + 1'b1;
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == S_IDLE && rx_fall) rx_div <= div_sel(bus.freq_control);
    if (rx_state == S_DATA && rx_tick) rx_word <= {rx_s, rx_word[DATA_W-1:1]};
  end

  // ---- SPI slave ----
  logic [DATA_W-1:0] spi_out, spi_in;
  logic [BIT_W-1:0]  spi_bit;
  logic              spi_skip, spi_done, spi_load, miso_q;

  assign spi_done = sclk_rise && (spi_bit == LAST_BIT);
  assign spi_load = cs_fall || spi_done;
  assign rx_pop   = spi_load;
  assign tx_push  = spi_done;
  assign tx_word  = {spi_in[DATA_W-2:0], mosi_s};

  // After a burst reload the trailing sclk fall of the finished word must not
  // shift, otherwise the new word's MSB would be lost; spi_skip swallows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_bit  <= '0;
      spi_skip <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      if (cs_s) begin
        spi_bit  <= '0;
        spi_skip <= 1'b0;
      end else if (sclk_rise) begin
        spi_bit  <= spi_done ? '0 : spi_bit + 1'b1;
        spi_skip <= spi_done;
      end else if (sclk_fall) begin
        spi_skip <= 1'b0;
      end
      miso_q <= (cs_s || cs_fall) ? 1'b0 : spi_out[DATA_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (spi_load)
      spi_out <= (rx_cnt_q != '0) ? rx_head : '0;
    else if (sclk_fall && !spi_skip)
      spi_out <= {spi_out[DATA_W-2:0], 1'b0};
    if (sclk_rise) spi_in <= tx_word;
  end

  // ---- UART transmitter ----
  uart_state_t       tx_state, tx_next;
  logic [DIV_W-1:0]  tx_div, tx_cnt;
  logic [BIT_W-1:0]  tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_tick, tx_level, tx_line;

  assign tx_tick = (tx_cnt == tx_div - 1'b1);

  // STOP chains straight into the next START so queued words leave no gap.
  always_comb begin
    tx_next  = tx_state;
    tx_pop   = 1'b0;
    tx_level = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (tx_cnt_q != '0) begin
          tx_pop  = 1'b1;
          tx_next = S_START;
        end
      end
      S_START: begin
        tx_level = 1'b0;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_level = tx_shift[0];
        if (tx_tick && tx_bit == LAST_BIT) tx_next = S_STOP;
      end
      S_STOP: begin
        if (tx_tick) begin
          tx_pop  = (tx_cnt_q != '0);
          tx_next = (tx_cnt_q != '0) ? S_START : S_IDLE;
        end
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_line  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_next;
      tx_line  <= tx_level;
      if (tx_pop || tx_state == S_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_state == S_DATA) tx_bit <= tx_bit + 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_shift <= tx_head;
      tx_div   <= div_sel(bus.freq_control);
    end else if (tx_state == S_DATA && tx_tick) begin
      tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
    end
  end

  // ---- sticky flags: set wins over clear ----
  logic rx_ovf_q, tx_ovf_q, ferr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_evt | (rx_ovf_q & ~bus.clear_flags);
      tx_ovf_q <= tx_ovf_evt | (tx_ovf_q & ~bus.clear_flags);
      ferr_q   <= rx_ferr    | (ferr_q   & ~bus.clear_flags);
    end
  end

  assign bus.uart_tx_d_out = tx_line;
  assign bus.miso          = miso_q;
  assign bus.rx_count      = rx_cnt_q;
  assign bus.tx_count      = tx_cnt_q;
  assign bus.rx_overflow   = rx_ovf_q;
  assign bus.tx_overflow   = tx_ovf_q;
  assign bus.frame_err     = ferr_q;
endmodule

// File: tb/tb_uart_spi_bridge.sv
// tb_uart_spi_bridge
//   Scoreboard bench for uart_spi_bridge (DATA_W=8, FIFO_DEPTH=4, DIV 16/20/24/12).
//   The RX FIFO is modelled as a byte queue; every SPI word load pops it (or
//   yields 0), every completed MOSI word becomes an expected UART TX frame.
//   Independent monitors decode MISO words and UART TX frames and compare
//   them against the expected queues.
module tb_uart_spi_bridge;
  localparam int DEPTH = 4;
  localparam int HALF  = 8;
  localparam int TXDIV = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_spi_bridge_if #(.CNT_W(3)) bus();

  uart_spi_bridge #(
    .DATA_W(8), .FIFO_DEPTH(DEPTH),
    .DIV_0(16), .DIV_1(20), .DIV_2(24), .DIV_3(12)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_model[$];
  logic [7:0] miso_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] mosi_q[$];
  bit m_rx_ovf = 0;
  bit m_ferr   = 0;
  bit ignore_tx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int div_of(input int f);
    case (f)
      0: return 16;
      1: return 20;
      2: return 24;
      default: return 12;
    endcase
  endfunction

  function automatic logic [7:0] m_pop();
    if (rx_model.size() > 0) return rx_model.pop_front();
    return 8'h00;
  endfunction

  task automatic uart_send(input logic [7:0] b, input bit stop_ok, input int div);
    bus.uart_rx_d_in = 1'b0;
    step(div);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx_d_in = b[i];
      step(div);
    end
    bus.uart_rx_d_in = stop_ok;
    step(div);
    bus.uart_rx_d_in = 1'b1;
    step(2);
    if (!stop_ok) m_ferr = 1;
    else if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else m_rx_ovf = 1;
  endtask

  // abort_bits > 0: single word cut short after that many sclk cycles.
  task automatic spi_transfer(input int nwords, input int abort_bits);
    logic [7:0] load, w;
    int bits;
    bus.cs_bar = 1'b0;
    load = m_pop();
    step(HALF);
    for (int k = 0; k < nwords; k++) begin
      w = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'($urandom);
      bits = (abort_bits > 0) ? abort_bits : 8;
      if (abort_bits == 0) miso_exp.push_back(load);
      for (int i = 0; i < bits; i++) begin
        bus.mosi = w[7-i];
        step(HALF);
        bus.sclk = 1'b1;
        step(HALF);
        bus.sclk = 1'b0;
      end
      if (abort_bits == 0) begin
        tx_exp.push_back(w);
        load = m_pop();
      end
    end
    bus.mosi = 1'b0;
    step(HALF);
    bus.cs_bar = 1'b1;
    step(2 * HALF);
  endtask

  task automatic pulse_clear();
    bus.clear_flags = 1'b1;
    step(1);
    bus.clear_flags = 1'b0;
    step(1);
  endtask

  task automatic wait_tx_drain();
    for (int t = 0; t < 4000; t++) begin
      if (tx_exp.size() == 0 && bus.tx_count == 0 && bus.uart_tx_d_out === 1'b1) break;
      step(1);
    end
    step(TXDIV);
    check("tx_drain", tx_exp.size(), 0);
  endtask

  // MISO monitor: collects 8 bits per word at the bench's sclk rising edges.
  initial begin : miso_mon
    logic [7:0] sh;
    int nb;
    sh = '0;
    nb = 0;
    forever begin
      @(posedge bus.sclk or posedge bus.cs_bar);
      if (bus.cs_bar) nb = 0;
      else begin
        sh = {sh[6:0], bus.miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (miso_exp.size() > 0) check("miso_word", sh, miso_exp.pop_front());
          else fail_now("miso_unexpected_word", sh);
        end
      end
    end
  end

  // UART TX monitor: samples each bit in its middle.
  initial begin : tx_mon
    logic [7:0] b;
    logic st, sp;
    b = '0;
    forever begin
      @(negedge bus.uart_tx_d_out);
      repeat (TXDIV / 2) @(posedge clk);
      #1 st = bus.uart_tx_d_out;
      for (int i = 0; i < 8; i++) begin
        repeat (TXDIV) @(posedge clk);
        #1 b[i] = bus.uart_tx_d_out;
      end
      repeat (TXDIV) @(posedge clk);
      #1 sp = bus.uart_tx_d_out;
      if (!ignore_tx) begin
        check("tx_start_bit", st, 1'b0);
        check("tx_stop_bit", sp, 1'b1);
        if (tx_exp.size() > 0) check("tx_byte", b, tx_exp.pop_front());
        else fail_now("tx_unexpected_frame", b);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bus.freq_control = 2'd0;
    bus.uart_rx_d_in = 1'b1;
    bus.cs_bar       = 1'b1;
    bus.sclk         = 1'b0;
    bus.mosi         = 1'b0;
    bus.clear_flags  = 1'b0;
    reset = 1'b1;
    step(3);
    check("reset_tx_line", bus.uart_tx_d_out, 1);
    check("reset_miso", bus.miso, 0);
    check("reset_rx_count", bus.rx_count, 0);
    check("reset_tx_count", bus.tx_count, 0);
    check("reset_flags", {bus.rx_overflow, bus.tx_overflow, bus.frame_err}, 0);
    reset = 1'b0;
    step(5);

    // UART RX -> SPI, and SPI 0x3C -> UART TX with latency checks
    uart_send(8'hA5, 1, 16);
    check("rx_count_a5", bus.rx_count, 1);
    mosi_q.push_back(8'h3C);
    fork
      spi_transfer(1, 0);
      begin
        for (int t = 0; t < 600; t++) begin
          @(posedge clk);
          #1;
          if (bus.tx_count != 0) break;
        end
        check("tx_count_pulse", bus.tx_count, 1);
        lat = 0;
        for (int t = 0; t < 10; t++) begin
          if (bus.uart_tx_d_out === 1'b0) break;
          step(1);
          lat++;
        end
        check("tx_start_latency", lat, 2);
        check("tx_count_popped", bus.tx_count, 0);
      end
    join
    check("rx_count_after_read", bus.rx_count, 0);
    wait_tx_drain();

    // burst with empty third word
    uart_send(8'h11, 1, 16);
    uart_send(8'h22, 1, 16);
    check("rx_count_two", bus.rx_count, 2);
    spi_transfer(3, 0);
    check("rx_count_after_burst", bus.rx_count, 0);
    wait_tx_drain();

    // randomized traffic with random RX baud selection
    for (int it = 0; it < 6; it++) begin
      int f, nb;
      f = $urandom_range(0, 3);
      nb = $urandom_range(1, 3);
      bus.freq_control = 2'(f);
      for (int j = 0; j < nb; j++) uart_send(8'($urandom), 1, div_of(f));
      bus.freq_control = 2'd0;
      check("rand_rx_count", bus.rx_count, rx_model.size());
      spi_transfer($urandom_range(1, 3), 0);
      check("rand_rx_count_after", bus.rx_count, rx_model.size());
      check("rand_rx_overflow", bus.rx_overflow, m_rx_ovf);
      wait_tx_drain();
    end
    if (rx_model.size() > 0) begin
      spi_transfer(rx_model.size(), 0);
      wait_tx_drain();
    end
    pulse_clear();
    m_rx_ovf = 0;

    // RX overflow and flag clear
    for (int j = 0; j < 5; j++) uart_send(8'($urandom), 1, 16);
    check("ovf_rx_count", bus.rx_count, rx_model.size());
    check("ovf_flag_set", bus.rx_overflow, m_rx_ovf);
    pulse_clear();
    m_rx_ovf = 0;
    check("ovf_flag_cleared", bus.rx_overflow, m_rx_ovf);
    check("ovf_count_kept", bus.rx_count, rx_model.size());
    spi_transfer(4, 0);
    wait_tx_drain();
    check("tx_overflow_none", bus.tx_overflow, 0);

    // framing error and start glitch
    uart_send(8'h96, 0, 16);
    check("frame_err_set", bus.frame_err, m_ferr);
    check("frame_err_count", bus.rx_count, rx_model.size());
    pulse_clear();
    m_ferr = 0;
    check("frame_err_cleared", bus.frame_err, 0);
    bus.uart_rx_d_in = 1'b0;
    step(4);
    bus.uart_rx_d_in = 1'b1;
    step(200);
    check("glitch_no_byte", bus.rx_count, 0);
    check("glitch_no_flag", bus.frame_err, 0);
    uart_send(8'h5A, 1, 16);
    check("after_glitch_byte", bus.rx_count, 1);

    // cs_bar abort after 5 bits: popped byte lost, nothing pushed to TX
    spi_transfer(1, 5);
    step(250);
    check("abort_rx_count", bus.rx_count, 0);
    check("abort_tx_count", bus.tx_count, 0);
    check("abort_tx_idle", bus.uart_tx_d_out, 1);

    // reset in the middle of a UART TX frame
    for (int j = 0; j < 3; j++) uart_send(8'($urandom), 1, 16);
    mosi_q.push_back(8'h00);
    spi_transfer(1, 0);
    check("pre_reset_rx_count", bus.rx_count, rx_model.size());
    step(20);
    check("pre_reset_tx_low", bus.uart_tx_d_out, 0);
    ignore_tx = 1;
    reset = 1'b1;
    step(1);
    check("reset_mid_tx_line", bus.uart_tx_d_out, 1);
    check("reset_mid_rx_count", bus.rx_count, 0);
    check("reset_mid_tx_count", bus.tx_count, 0);
    reset = 1'b0;
    rx_model.delete();
    tx_exp.delete();
    step(300);
    ignore_tx = 0;

    // recovery after reset
    uart_send(8'hC3, 1, 16);
    spi_transfer(1, 0);
    wait_tx_drain();
    check("final_miso_queue", miso_exp.size(), 0);
    check("final_rx_count", bus.rx_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
